// File: rtl/simple_io_port.sv
// rtl/simple_io_port.sv - SIMPLE core I/O port: OUT FIFO paced onto 4-digit 7-seg display, synchronized IN switches
// Optional switch debounce enabled by defining SIMPLE_IO_DEBOUNCE_EN.
module simple_io_port #(
    parameter int FIFO_DEPTH      = 4,
    parameter int HOLD_CYCLES     = 1000000,
    parameter int SCAN_DIV        = 1024,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        systemRunning,
    input  logic        outputEnable,
    input  logic [15:0] outData,
    input  logic        inputEnable,
    output logic [15:0] inData,
    output logic        inRead,
    input  logic [15:0] switches,
    output logic        outFull,
    output logic        overflow,
    output logic [3:0]  digitSel,
    output logic [7:0]  segData
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || HOLD_CYCLES < 1 ||
        SCAN_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("simple_io_port: illegal parameter set");
    end

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          full, pop, push, strobe_out;
    logic [15:0]   disp_reg;
    logic [HW-1:0] hold_cnt;
    logic          hold_done;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    nibble;
    logic [6:0]    seg7;
    logic [15:0]   sync1, sync2;

    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = (count != '0) && hold_done;
    assign strobe_out = outputEnable && systemRunning;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push       = strobe_out && (!full || pop);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= outData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            outFull  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            outFull <= (count_next == CW'(FIFO_DEPTH));
            if (strobe_out && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_reg  <= '0;
            hold_cnt  <= '0;
            hold_done <= 1'b1;
        end else if (pop) begin
            disp_reg  <= mem[rd_ptr];
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (!hold_done) begin
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                hold_done <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    always_comb begin
        nibble = disp_reg[{digit_idx, 2'b00} +: 4];
        seg7   = 7'h7F;
        case (nibble)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    end

    // Decimal point on digit 0 flags a dropped OUT value.
    assign segData  = {~(overflow && (digit_idx == 2'd0)), seg7};
    assign digitSel = ~(4'b0001 << digit_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            inRead <= 1'b0;
        end else begin
            sync1  <= switches;
            sync2  <= sync1;
            inRead <= inputEnable && systemRunning;
        end
    end

`ifdef SIMPLE_IO_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [15:0]   cand;
    logic [DW-1:0] stable_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand       <= '0;
            stable_cnt <= '0;
            inData     <= '0;
        end else if (sync2 != cand) begin
            cand       <= sync2;
            stable_cnt <= '0;
        end else if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            inData <= cand;
        end else begin
            stable_cnt <= stable_cnt + DW'(1);
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inData <= '0;
        end else begin
            inData <= sync2;
        end
    end
`endif
endmodule

// File: tb/tb_simple_io_port.sv
// tb/tb_simple_io_port.sv - scoreboard bench for simple_io_port (display queue checked by a separate monitor)
module tb_simple_io_port;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        systemRunning = 1'b0;
    logic        outputEnable = 1'b0;
    logic        inputEnable = 1'b0;
    logic [15:0] outData = '0;
    logic [15:0] switches = '0;
    logic [15:0] inData;
    logic        inRead, outFull, overflow;
    logic [3:0]  digitSel;
    logic [7:0]  segData;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pop = -100;
    logic [15:0] exp_q[$];
    logic [15:0] last_disp = '0;
    logic [15:0] mon_exp;
    logic [3:0]  sel_tab[4];
    logic [7:0]  seg_tab[4];
    logic [15:0] vals[6];
    bit          ok;
    int          lat;

    simple_io_port #(
        .FIFO_DEPTH(4), .HOLD_CYCLES(4), .SCAN_DIV(2), .DEBOUNCE_CYCLES(3)
    ) dut (
        .clock(clock), .reset(reset), .systemRunning(systemRunning),
        .outputEnable(outputEnable), .outData(outData), .inputEnable(inputEnable),
        .inData(inData), .inRead(inRead), .switches(switches), .outFull(outFull),
        .overflow(overflow), .digitSel(digitSel), .segData(segData)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Monitor: every change of the displayed value must be the next scoreboard entry.
    always @(negedge clock) begin
        if (reset) begin
            last_disp = '0;
            last_pop  = -100;
        end else if (dut.disp_reg !== last_disp) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL disp_unexpected: got %h want no change", dut.disp_reg);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dut.disp_reg !== mon_exp) begin
                    failures++;
                    $display("FAIL disp_order: got %h want %h", dut.disp_reg, mon_exp);
                end
            end
            checks++;
            if (cyc - last_pop < 4) begin
                failures++;
                $display("FAIL disp_hold: got gap %0d want >=4", cyc - last_pop);
            end
            last_pop  = cyc;
            last_disp = dut.disp_reg;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic sync_digit0(output bit found);
        logic [3:0] prev;
        found = 1'b0;
        prev = digitSel;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (digitSel == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = digitSel;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inData"},   32'(inData),   32'h0);
        check({tag, "_inRead"},   32'(inRead),   32'h0);
        check({tag, "_outFull"},  32'(outFull),  32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
        check({tag, "_digitSel"}, 32'(digitSel), 32'hE);
        check({tag, "_segData"},  32'(segData),  32'hC0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{8'h8E, 8'hA4, 8'h88, 8'hF9};

        #2;
        check_reset_values("por");
        step(2);
        reset = 1'b0;
        systemRunning = 1'b1;
        step(2);

        inputEnable = 1'b1;
        step(1);
        inputEnable = 1'b0;
        check("inread_pulse", 32'(inRead), 32'h1);
        step(1);
        check("inread_clear", 32'(inRead), 32'h0);

        // Single OUT value and its scanned digits.
        outData = 16'h1A2F;
        outputEnable = 1'b1;
        exp_q.push_back(16'h1A2F);
        step(1);
        outputEnable = 1'b0;
        check("single_outfull", 32'(outFull), 32'h0);
        step(1);
        sync_digit0(ok);
        check("single_scan_sync", 32'(ok), 32'h1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("single_sel%0d", i), 32'(digitSel), 32'(sel_tab[i/2]));
            check($sformatf("single_seg%0d", i), 32'(segData), 32'(seg_tab[i/2]));
            step(1);
        end
        step(10);

        // Full FIFO: push coincides with the pop that frees a slot.
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        for (int i = 0; i < 5; i++) begin
            outData = vals[i];
            outputEnable = 1'b1;
            exp_q.push_back(vals[i]);
            step(1);
        end
        outputEnable = 1'b0;
        check("pp_full_e4", 32'(outFull), 32'h1);
        step(1);
        check("pp_full_e5", 32'(outFull), 32'h1);
        outData = vals[5];
        outputEnable = 1'b1;
        exp_q.push_back(vals[5]);
        step(1);
        outputEnable = 1'b0;
        check("pp_no_drop", 32'(overflow), 32'h0);
        check("pp_still_full", 32'(outFull), 32'h1);
        step(40);
        check("pp_drained_outfull", 32'(outFull), 32'h0);
        check("pp_drained_queue", 32'(exp_q.size()), 32'h0);

        // Overflow: six back-to-back OUTs, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            outData = 16'(i + 1);
            outputEnable = 1'b1;
            if (i < 5) exp_q.push_back(16'(i + 1));
            step(1);
            check($sformatf("ovf_outfull%0d", i), 32'(outFull), (i >= 4) ? 32'h1 : 32'h0);
            check($sformatf("ovf_flag%0d", i), 32'(overflow), (i == 5) ? 32'h1 : 32'h0);
        end
        outputEnable = 1'b0;
        step(40);
        check("ovf_drained", 32'(exp_q.size()), 32'h0);
        sync_digit0(ok);
        check("ovf_scan_sync", 32'(ok), 32'h1);
        check("ovf_dp_digit0", 32'(segData), 32'h12);
        step(2);
        check("ovf_dp_digit1", 32'(segData), 32'hC0);

        // Switch input.
`ifdef SIMPLE_IO_DEBOUNCE_EN
        lat = 6;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) switches = (switches == 16'h0) ? 16'h00FF : 16'h0000;
            step(1);
            check($sformatf("db_toggle%0d", i), 32'(inData), 32'h0);
        end
`else
        lat = 3;
`endif
        switches = 16'h0000;
        step(10);
        check("sw_idle", 32'(inData), 32'h0);
        switches = 16'h00FF;
        for (int k = 0; k < lat; k++) begin
            step(1);
            check($sformatf("sw_lat%0d", k), 32'(inData), (k == lat - 1) ? 32'h00FF : 32'h0);
        end

        // Strobes ignored while the core is halted.
        systemRunning = 1'b0;
        outputEnable = 1'b1;
        inputEnable = 1'b1;
        outData = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("halt_inread%0d", i), 32'(inRead), 32'h0);
            check($sformatf("halt_outfull%0d", i), 32'(outFull), 32'h0);
        end
        outputEnable = 1'b0;
        inputEnable = 1'b0;
        systemRunning = 1'b1;
        step(10);
        sync_digit0(ok);
        check("halt_scan_sync", 32'(ok), 32'h1);
        check("halt_display_kept", 32'(segData), 32'h12);

        // Asynchronous reset in the middle of a cycle with a full FIFO.
        for (int i = 0; i < 5; i++) begin
            outData = 16'h0A00 + 16'(i + 1);
            outputEnable = 1'b1;
            if (i == 0) exp_q.push_back(16'h0A01);
            step(1);
        end
        outputEnable = 1'b0;
        check("pre_reset_full", 32'(outFull), 32'h1);
        check("pre_reset_indata", 32'(inData), 32'h00FF);
        #3;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_values("mid");
        step(2);
        reset = 1'b0;
        step(30);
        check("post_reset_outfull", 32'(outFull), 32'h0);
        sync_digit0(ok);
        check("post_reset_scan_sync", 32'(ok), 32'h1);
        check("post_reset_seg", 32'(segData), 32'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simple_io_port.md
# simple_io_port

Memory-stage I/O responder for the pipelined SIMPLE core; the far end of the decoder's `outputEnable` / `inputEnable` strobes. OUT values are buffered in a small FIFO and paced onto a 4-digit multiplexed hex 7-segment display. Switch input is synchronized and debounced so IN reads a stable 16-bit value. When the FIFO is full, the block asserts a stall request back to the pipeline.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: OUT buffer entries; power of two, ≥2.
- `HOLD_CYCLES`, default 1000000: minimum cycles each OUT value stays displayed.
- `SCAN_DIV`, default 1024: cycles per display digit.
- `DEBOUNCE_CYCLES`, default 16: cycles the synchronized switch value must be stable before it is accepted.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `systemRunning` in 1: strobes are honoured only while high.
- `outputEnable` in 1: OUT strobe.
- `outData` in 16: OUT value.
- `inputEnable` in 1: IN strobe.
- `inData` out 16: debounced switch value, registered.
- `inRead` out 1: one-cycle pulse, registered, marking an accepted IN.
- `switches` in 16: asynchronous board switches.
- `outFull` out 1: FIFO full; stall request.
- `overflow` out 1: sticky; set when an OUT is dropped.
- `digitSel` out 4: active-low digit enable.
- `segData` out 8: active-low segments; bit 7 = dp, bits 6:0 = gfedcba.

## Operation

OUT FIFO:
- Write when `outputEnable & systemRunning & (!full | pop)`.
- When full with no pop in the same cycle: data is dropped and `overflow` ← 1.
- `overflow` clears only on reset.

Display pacing:
- `holdDone` resets to 1.
- Pop when `count>0 & holdDone`. On pop: `dispReg` ← head, `holdCnt` ← 0, `holdDone` ← 0.
- `holdCnt` increments while `!holdDone`; at `HOLD_CYCLES-1`, `holdDone` ← 1.
- When the FIFO is empty, the last value remains displayed.

Scan:
- `scanCnt` counts 0..`SCAN_DIV-1`; at wrap, `digitIdx` increments mod 4.
- Digit k shows nibble `dispReg[4k+3:4k]`; `digitSel` has bit k low.
- Hex encoding, active-low: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- dp is lit (bit 7 = 0) only on digit 0 and only when `overflow`=1.

Input:
- `switches` passes through a 2-flop synchronizer.
- `stableCnt` resets whenever the sync value differs from the candidate.
- After `DEBOUNCE_CYCLES` equal cycles, `inData` ← candidate.
- `inRead` = registered `inputEnable & systemRunning`.
- Strobes with `systemRunning`=0 are ignored; FIFO state and pacing are unaffected.

## Timing

- Reset values:
  - `inData`=0, `inRead`=0, `outFull`=0, `overflow`=0.
  - `digitSel`=4'b1110, `segData`=8'hC0.
  - FIFO empty, `dispReg`=0, `holdDone`=1.
- OUT write at edge N:
  - `count` updates at N.
  - `outFull` is registered and reflects the post-N count.
  - If `holdDone`, pop at edge N+1; `segData` shows the new value after edge N+1 for the active digit.
- Simultaneous push and pop:
  - Count unchanged.
  - Allowed when full (no drop).
  - Pop takes the old head.
- Pointers wrap modulo `FIFO_DEPTH`. Count has width log2(`FIFO_DEPTH`)+1 so that full and empty are distinguished.
- Switch change to `inData`: 2 + `DEBOUNCE_CYCLES` + 1 cycles (debounce enabled).
- Reset asserted mid-operation: everything returns to reset values immediately and asynchronously; FIFO contents are discarded.

## Configuration

- `SIMPLE_IO_DEBOUNCE_EN` defined: debounce as above.
- `SIMPLE_IO_DEBOUNCE_EN` undefined:
  - Debounce counter removed.
  - `inData` ← synchronizer output each cycle (latency 3 cycles).
  - `DEBOUNCE_CYCLES` is ignored.

## Test plan

Bench parameters: `FIFO_DEPTH`=4, `HOLD_CYCLES`=4, `SCAN_DIV`=2, `DEBOUNCE_CYCLES`=3.

- Reset check: pulse `reset` asynchronously mid-cycle → all outputs at reset values at once; `segData`=C0 and `digitSel`=1110.
- Single OUT: `outData`=16'h1A2F with `outputEnable` one cycle → `dispReg`=1A2F two edges later; digits cycle 1110/1101/1011/0111 every 2 cycles showing 8E, A4, 88, F9.
- Overflow: 6 back-to-back OUTs 1..6 → `outFull` set after the 4th FIFO entry; exactly one value (6) is dropped; `overflow`=1; digit 0 `segData` bit 7 = 0; values 1..5 are displayed ≥4 cycles apart, in order.
- Full push+pop: FIFO full and `holdDone` at the same edge as `outputEnable` → no drop; `overflow` stays 0.
- Debounce: `switches` toggles 16'h00FF↔0 every 2 cycles, then holds 16'h00FF → `inData` stays 0 during toggling and equals 00FF 6 cycles after the last change; repeat with the macro undefined → latency 3.
- `systemRunning`=0 with strobes → no FIFO change; `inRead` stays 0.
